// File: rtl/somador_serial_param.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, fixed NDIG+2 cycle latency.
// Optional macro SOMADOR_SATURATE_EN replaces an overflowed result with the saturated value.
module somador_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OV,
    output logic             Z,
    output logic             N
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic             carry_reg;
    logic             c_msb_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ov_reg;
    logic             z_reg;
    logic             n_reg;
    logic             done_reg;

    logic [DIGIT:0]   dig_sum;
    logic [WIDTH-1:0] sum_sh_next;
    logic [WIDTH-1:0] s_next;
    logic             ov_next;
    logic             last_dig;

    assign dig_sum  = {1'b0, a_sh_reg[DIGIT-1:0]} + {1'b0, b_sh_reg[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_reg};
    assign last_dig = (cnt_reg == CW'(NDIG - 1));

    // Result digits enter from the MSB side so the LSB digit ends up at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign sum_sh_next = dig_sum[DIGIT-1:0];
        end else begin : g_multi
            assign sum_sh_next = {dig_sum[DIGIT-1:0], sum_sh_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    // After the last digit carry_reg holds the carry out of the MSB.
    assign ov_next = c_msb_reg ^ carry_reg;

`ifdef SOMADOR_SATURATE_EN
    logic a_msb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            a_msb_reg <= A[WIDTH-1];
        end
    end

    always_comb begin
        s_next = sum_sh_reg;
        if (ov_next) begin
            s_next = a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign s_next = sum_sh_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            c_msb_reg  <= 1'b0;
            cnt_reg    <= '0;
            s_reg      <= '0;
            cout_reg   <= 1'b0;
            ov_reg     <= 1'b0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= A;
                        b_sh_reg  <= B ^ {WIDTH{SUB}};
                        carry_reg <= SUB;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> DIGIT;
                    b_sh_reg   <= b_sh_reg >> DIGIT;
                    sum_sh_reg <= sum_sh_next;
                    carry_reg  <= dig_sum[DIGIT];
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_dig) begin
                        // Carry into the MSB recovered from the MSB sum bit and its operands.
                        c_msb_reg <= dig_sum[DIGIT-1] ^ a_sh_reg[DIGIT-1] ^ b_sh_reg[DIGIT-1];
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    s_reg     <= s_next;
                    cout_reg  <= carry_reg;
                    ov_reg    <= ov_next;
                    z_reg     <= (s_next == '0);
                    n_reg     <= s_next[WIDTH-1];
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready = (state_reg == IDLE);
    assign done  = done_reg;
    assign S     = s_reg;
    assign Cout  = cout_reg;
    assign OV    = ov_reg;
    assign Z     = z_reg;
    assign N     = n_reg;
endmodule

// File: tb/tb_somador_serial_param.sv
// Bench for somador_serial_param: 8/2 and 16/16 instances checked every cycle against
// an arithmetic model, plus directed cases with literal expectations.
module tb_somador_serial_param;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, done8, c8, ov8, z8, n8;
    logic [7:0]  s8;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, done16, c16, ov16, z16, n16;
    logic [15:0] s16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    somador_serial_param #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .SUB(sub8), .A(a8), .B(b8),
        .ready(ready8), .done(done8), .S(s8), .Cout(c8), .OV(ov8), .Z(z8), .N(n8)
    );

    somador_serial_param #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .SUB(sub16), .A(a16), .B(b16),
        .ready(ready16), .done(done16), .S(s16), .Cout(c16), .OV(ov16), .Z(z16), .N(n16)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: full-width sum, overflow from operand/result signs.
    task automatic calc(input int w, input logic [63:0] a, input logic [63:0] b, input bit sub,
                        output logic [63:0] s, output bit c, output bit ov, output bit z, output bit n);
        logic [63:0] mask;
        logic [63:0] bb;
        logic [64:0] full;
        mask = (64'd1 << w) - 64'd1;
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, sub};
        c    = full[w];
        s    = full[63:0] & mask;
        ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
`ifdef SOMADOR_SATURATE_EN
        if (ov) s = a[w-1] ? (64'd1 << (w-1)) : (mask >> 1);
`endif
        z = (s == 64'd0);
        n = s[w-1];
    endtask

    int          m_cnt[2] = '{0, 0};
    logic [63:0] m_s[2] = '{64'd0, 64'd0};
    bit          m_c[2] = '{0, 0}, m_ov[2] = '{0, 0}, m_z[2] = '{0, 0}, m_n[2] = '{0, 0};
    bit          m_done[2] = '{0, 0};
    logic [63:0] p_s[2];
    bit          p_c[2], p_ov[2], p_z[2], p_n[2];

    task automatic mreset(input int k);
        m_cnt[k] = 0; m_s[k] = 0; m_c[k] = 0; m_ov[k] = 0; m_z[k] = 0; m_n[k] = 0; m_done[k] = 0;
    endtask

    task automatic mstep(input int k, input bit st, input logic [63:0] a, input logic [63:0] b, input bit sub);
        int w;
        int nd;
        logic [63:0] s;
        bit c, ov, z, n;
        w  = (k == 0) ? 8 : 16;
        nd = (k == 0) ? 4 : 1;
        m_done[k] = 0;
        if (m_cnt[k] > 0) begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
                m_s[k] = p_s[k]; m_c[k] = p_c[k]; m_ov[k] = p_ov[k];
                m_z[k] = p_z[k]; m_n[k] = p_n[k]; m_done[k] = 1;
            end
        end else if (st) begin
            calc(w, a, b, sub, s, c, ov, z, n);
            p_s[k] = s; p_c[k] = c; p_ov[k] = ov; p_z[k] = z; p_n[k] = n;
            m_cnt[k] = nd + 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset(0);
        else mstep(0, start8, {56'd0, a8}, {56'd0, b8}, sub8);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset(1);
        else mstep(1, start16, {48'd0, a16}, {48'd0, b16}, sub16);
    end

    always @(negedge clk) begin
        chk("ready8", {63'd0, ready8}, {63'd0, m_cnt[0] == 0});
        chk("done8",  {63'd0, done8},  {63'd0, m_done[0]});
        chk("S8",     {56'd0, s8},     m_s[0]);
        chk("Cout8",  {63'd0, c8},     {63'd0, m_c[0]});
        chk("OV8",    {63'd0, ov8},    {63'd0, m_ov[0]});
        chk("Z8",     {63'd0, z8},     {63'd0, m_z[0]});
        chk("N8",     {63'd0, n8},     {63'd0, m_n[0]});
        chk("ready16", {63'd0, ready16}, {63'd0, m_cnt[1] == 0});
        chk("done16",  {63'd0, done16},  {63'd0, m_done[1]});
        chk("S16",     {48'd0, s16},     m_s[1]);
        chk("Cout16",  {63'd0, c16},     {63'd0, m_c[1]});
        chk("OV16",    {63'd0, ov16},    {63'd0, m_ov[1]});
        chk("Z16",     {63'd0, z16},     {63'd0, m_z[1]});
        chk("N16",     {63'd0, n16},     {63'd0, m_n[1]});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one operation, scramble operands afterwards, and measure cycles from start to done.
    task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input bit sub, output int lat);
        tick();
        if (k == 0) begin a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; start8 = 1'b1; end
        else begin a16 = a; b16 = b; sub16 = sub; start16 = 1'b1; end
        @(posedge clk);
        tick();
        start8 = 1'b0; start16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((k == 0 && done8) || (k == 1 && done16)) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat;
        int nd;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_S8", {56'd0, s8}, 64'h0);
        chk("rst_ready8", {63'd0, ready8}, 64'd1);
        chk("rst_done8", {63'd0, done8}, 64'd0);
        rst_n = 1'b1;

        op(0, 16'd100, 16'd27, 1'b0, lat);
        chk("t23_lat", lat, 6);
        chk("t23_S", {56'd0, s8}, 64'h7F);
        chk("t23_flags", {60'd0, c8, ov8, z8, n8}, 64'h0);

        op(0, 16'd100, 16'd28, 1'b0, lat);
        chk("t24_OV", {63'd0, ov8}, 64'd1);
`ifdef SOMADOR_SATURATE_EN
        chk("t24_S", {56'd0, s8}, 64'h7F);
        chk("t24_N", {63'd0, n8}, 64'd0);
`else
        chk("t24_S", {56'd0, s8}, 64'h80);
        chk("t24_N", {63'd0, n8}, 64'd1);
`endif

        op(0, 16'h00FF, 16'h0001, 1'b0, lat);
        chk("t25a_S", {56'd0, s8}, 64'h00);
        chk("t25a_CZ", {62'd0, c8, z8}, 64'h3);
        chk("t25a_OV", {63'd0, ov8}, 64'd0);
        op(0, 16'd5, 16'd7, 1'b1, lat);
        chk("t25b_S", {56'd0, s8}, 64'hFE);
        chk("t25b_CN", {62'd0, c8, n8}, 64'h1);
        chk("t25b_OV", {63'd0, ov8}, 64'd0);

        // Second start while busy must be ignored.
        tick(); a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        tick(); start8 = 1'b0;
        tick(); a8 = 8'd50; b8 = 8'd60; start8 = 1'b1;
        tick(); start8 = 1'b0;
        nd = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("t26_ndone", nd, 1);
        chk("t26_S", {56'd0, s8}, 64'd30);

        // Reset mid-RUN aborts the operation.
        tick(); a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
        @(posedge clk);
        tick(); start8 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t27_S", {56'd0, s8}, 64'd0);
        chk("t27_ready", {63'd0, ready8}, 64'd1);
        tick(); tick();
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("t27_ndone", nd, 0);
        op(0, 16'd3, 16'd4, 1'b0, lat);
        chk("t27_S_after", {56'd0, s8}, 64'd7);

        op(1, 16'h8000, 16'h8000, 1'b0, lat);
        chk("t28_lat", lat, 3);
        chk("t28_COV", {62'd0, c16, ov16}, 64'h3);
`ifdef SOMADOR_SATURATE_EN
        chk("t28_S", {48'd0, s16}, 64'h8000);
        chk("t28_Z", {63'd0, z16}, 64'd0);
`else
        chk("t28_S", {48'd0, s16}, 64'h0000);
        chk("t28_Z", {63'd0, z16}, 64'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_n   = ($urandom_range(0, 399) != 0);
            start8  = ($urandom_range(0, 2) == 0);
            start16 = ($urandom_range(0, 2) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        end
        tick();
        rst_n = 1'b1; start8 = 1'b0; start16 = 1'b0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/somador_serial_param.md
SOMADOR_SERIAL_PARAM -- requirements
Module: somador_serial_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal: 2..64).
REQ-002 The block SHALL have parameter DIGIT, default 2, bits added per cycle (legal: 1..WIDTH, WIDTH divisible by DIGIT); NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, operation request, accepted only when ready=1.
REQ-006 The block SHALL have port SUB, input, 1, 0 = A+B, 1 = A-B, sampled with start.
REQ-007 The block SHALL have ports A and B, input, WIDTH each, two's-complement operands sampled with start.
REQ-008 The block SHALL have port ready, output, 1, high only in IDLE.
REQ-009 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 The block SHALL have port S, output, WIDTH, registered result.
REQ-011 The block SHALL have ports Cout, OV, Z, N, output, 1 each: carry out of MSB, signed overflow, S==0, S[WIDTH-1].

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE: on start=1, capture A, B^{WIDTH{SUB}}, carry=SUB, digit counter=0, then go to RUN.
- RUN: add the DIGIT LSBs of the operand shift registers plus carry each cycle, shift the result in from the MSB side, and increment the counter; after NDIG RUN cycles go to DONE.
- DONE: load S/flags, done=1 for one cycle, then go to IDLE.
REQ-013 Latency SHALL be fixed: start sampled at edge t gives done=1 in the cycle after edge t+NDIG+1 (NDIG+2 cycles, IDLE to IDLE).
REQ-014 start while ready=0 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-015 OV SHALL equal (carry into MSB) XOR (carry out of MSB); Cout SHALL be the raw MSB carry (in subtraction, 1 = no borrow).
REQ-016 S, Cout, OV, Z, N SHALL change only in the DONE cycle and SHALL hold until the next DONE; Z and N SHALL reflect the final S.
REQ-017 A and B changing after acceptance SHALL NOT affect the result in flight.
REQ-018 For DIGIT=WIDTH, RUN SHALL last exactly one cycle.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE, clear the operand registers and counter, and set S=0, Cout=0, OV=0, Z=0, N=0, done=0, ready=1.
REQ-020 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-021 With macro SOMADOR_SATURATE_EN defined, when OV=1 the DONE stage SHALL load S with the saturated value: 0 followed by WIDTH-1 ones if A[MSB]=0, else 1 followed by WIDTH-1 zeros. OV SHALL still be reported as 1, Cout SHALL stay raw, and Z/N SHALL follow the saturated S.
REQ-022 Without SOMADOR_SATURATE_EN, S SHALL be the wrapped WIDTH-bit sum and no saturation logic SHALL be present.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-023 A=100, B=27, SUB=0 -> S=0x7F, Cout=0, OV=0, Z=0, N=0; done exactly NDIG+2=6 cycles after start.
REQ-024 A=100, B=28, SUB=0 -> OV=1, N=1, S=0x80; with SOMADOR_SATURATE_EN instead S=0x7F, OV=1, N=0.
REQ-025 A=0xFF, B=0x01, SUB=0 -> S=0x00, Cout=1, OV=0, Z=1; then A=5, B=7, SUB=1 -> S=0xFE, Cout=0, N=1, OV=0.
REQ-026 start pulsed in RUN with different operands -> ignored, first result unchanged, exactly one done pulse.
REQ-027 rst_n low in mid-RUN -> outputs zero, ready=1, no done; a new start after release completes correctly.
REQ-028 WIDTH=16, DIGIT=16, A=0x8000, B=0x8000 -> S=0x0000, Cout=1, OV=1, Z=1; latency 3 cycles.
